// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multicycle MIPS core.
// Steps the shared datapath through fetch/decode/execute/memory/writeback,
// decodes opcode/func, and stalls on (or aborts after) the memory handshake.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_br,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       readmem,
    output logic       writemem,
    output logic       ir_write,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [3:0] aluop,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JR     = 4'd12
    } state_e;

    localparam logic [3:0] ALU_SLL = 4'h0;
    localparam logic [3:0] ALU_SRL = 4'h2;
    localparam logic [3:0] ALU_SRA = 4'h3;
    localparam logic [3:0] ALU_SLT = 4'h5;
    localparam logic [3:0] ALU_SUB = 4'hA;
    localparam logic [3:0] ALU_ADD = 4'hB;
    localparam logic [3:0] ALU_AND = 4'hC;
    localparam logic [3:0] ALU_OR  = 4'hD;
    localparam logic [3:0] ALU_NOR = 4'hF;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       in_wait;
    logic       expire;
    logic       unused_zero;

    // Branch resolution on zero happens in the datapath via pc_write_br.
    assign unused_zero = zero;

    function automatic logic rtype_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'd0, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34, 6'd35,
            6'd36, 6'd37, 6'd39, 6'd42: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] rtype_aluop(input logic [5:0] f);
        logic [3:0] op;
        case (f)
            6'd0:         op = ALU_SLL;
            6'd2:         op = ALU_SRL;
            6'd3:         op = ALU_SRA;
            6'd32, 6'd33: op = ALU_ADD;
            6'd34, 6'd35: op = ALU_SUB;
            6'd36:        op = ALU_AND;
            6'd37:        op = ALU_OR;
            6'd39:        op = ALU_NOR;
            6'd42:        op = ALU_SLT;
            default:      op = 4'h0;
        endcase
        return op;
    endfunction

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign expire  = in_wait && !mem_ready && (wait_q >= WAIT_LIMIT);

    // Next-state selection, decode faults and memory-wait accounting.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (expire) begin
                    timeout_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    6'h00: begin
                        if (func == 6'd8) begin
                            state_d = S_JR;
                        end else if (rtype_legal(func)) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h04:        state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08, 6'h09: state_d = S_IMMEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (expire) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (expire) begin
                    state_d   = S_FETCH;
                    timeout_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase

        // Only wait states can hold, so "same state, no abort" means still waiting;
        // any transition (including the FETCH->FETCH abort) restarts the count.
        if ((state_d == state_q) && !timeout_d) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = '0;
        end
    end

    // State, wait counter and the registered fault pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Datapath controls decoded from the current state; writes are suppressed during reset.
    always_comb begin
        pc_write    = 1'b0;
        pc_write_br = 1'b0;
        pc_src      = 2'd0;
        iord        = 1'b0;
        readmem     = 1'b0;
        writemem    = 1'b0;
        ir_write    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrc_a    = 1'b0;
        alusrc_b    = 2'd0;
        aluop       = 4'h0;
        case (state_q)
            S_FETCH: begin
                readmem = !expire;
                if (mem_ready) begin
                    ir_write = !rst;
                    pc_write = !rst;
                    alusrc_b = 2'd1;
                    aluop    = ALU_ADD;
                end
            end
            S_DECODE: begin
                alusrc_b = 2'd3;
                aluop    = ALU_ADD;
            end
            S_MEMADR, S_IMMEX: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'd2;
                aluop    = ALU_ADD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                readmem = !expire;
            end
            S_MEMWB: begin
                regwrite = !rst;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                writemem = !expire && !rst;
            end
            S_EXEC: begin
                alusrc_a = 1'b1;
                aluop    = rtype_aluop(func);
            end
            S_ALUWB: begin
                regwrite = !rst;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrc_a    = 1'b1;
                aluop       = ALU_SUB;
                pc_write_br = !rst;
                pc_src      = 2'd1;
            end
            S_JUMP: begin
                pc_write = !rst;
                pc_src   = 2'd2;
            end
            S_IMMWB: regwrite = !rst;
            S_JR: begin
                pc_write = !rst;
                pc_src   = 2'd3;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle stimulus with hand-computed
// state/control expectations for each instruction class and fault path.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_br, iord, readmem, writemem, ir_write;
    logic       regdst, memtoreg, regwrite, alusrc_a, illegal, mem_timeout;
    logic [1:0] pc_src, alusrc_b;
    logic [3:0] aluop, state;

    int n_checks = 0;
    int n_fail = 0;

    multicycle_control #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_br(pc_write_br),
        .pc_src(pc_src), .iord(iord), .readmem(readmem), .writemem(writemem),
        .ir_write(ir_write), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .aluop(aluop), .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Observed vector: state, illegal, mem_timeout, then the 18 control bits.
    logic [17:0] outs;
    logic [23:0] obs;
    assign outs = {pc_write, pc_write_br, pc_src, iord, readmem, writemem, ir_write,
                   regdst, memtoreg, regwrite, alusrc_a, alusrc_b, aluop};
    assign obs  = {state, illegal, mem_timeout, outs};

    // Control words: {pcw, pcwbr, pc_src, iord, rd, wr, irw, regdst, m2r, rw, asa, asb, aluop}
    localparam logic [17:0] O_NONE    = '0;
    localparam logic [17:0] O_FWAIT   = {1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_FGO     = {1'b1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,4'hB};
    localparam logic [17:0] O_FRST    = {1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,4'hB};
    localparam logic [17:0] O_DEC     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,4'hB};
    localparam logic [17:0] O_MADR    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,4'hB};
    localparam logic [17:0] O_MRD     = {1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_MWB     = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_MWR     = {1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_MWR_OFF = {1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_EXEC    = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,4'h0};
    localparam logic [17:0] O_ALUWB   = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_BR      = {1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,4'hA};
    localparam logic [17:0] O_JMP     = {1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_JR      = {1'b1,1'b0,2'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,4'h0};
    localparam logic [17:0] O_IMMEX   = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,4'hB};
    localparam logic [17:0] O_IMMWB   = {1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,4'h0};

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DEC = 4'd1, ST_MADR = 4'd2, ST_MRD = 4'd3;
    localparam logic [3:0] ST_MWB = 4'd4, ST_MWR = 4'd5, ST_EXEC = 4'd6, ST_ALUWB = 4'd7;
    localparam logic [3:0] ST_BR = 4'd8, ST_JMP = 4'd9, ST_IMMEX = 4'd10, ST_IMMWB = 4'd11;
    localparam logic [3:0] ST_JR = 4'd12;

    function automatic logic [23:0] E(input logic [3:0] s, input logic ill, input logic tmo,
                                      input logic [17:0] o);
        return {s, ill, tmo, o};
    endfunction

    // Stimulus word: {rst, mem_ready, zero, opcode, func}
    function automatic logic [14:0] S(input logic r, input logic m, input logic z,
                                      input logic [5:0] op, input logic [5:0] fn);
        return {r, m, z, op, fn};
    endfunction

    task automatic test_reset();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b1, 1'b1, 1'b0, 6'h00, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FRST));
        st.push_back(S(1'b1, 1'b0, 1'b0, 6'h00, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        @(posedge clk); #1;
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_fetch_timeout();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        // mem_ready arrives on the last allowed cycle: completes, no pulse
        for (int k = 0; k < 15; k++) begin
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        end
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_JMP, 1'b0, 1'b0, O_JMP));
        // no mem_ready: abort on cycle 15, pulse follows while FETCH restarts
        for (int k = 0; k < 15; k++) begin
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        end
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_NONE));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b1, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_JMP, 1'b0, 1'b0, O_JMP));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL fetch_timeout step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_rtype();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        logic [5:0]  fns [11] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2, 6'd3};
        logic [3:0]  ops [11] = '{4'hB, 4'hB, 4'hA, 4'hA, 4'hC, 4'hD, 4'hF, 4'h5, 4'h0, 4'h2, 4'h3};
        for (int k = 0; k < 11; k++) begin
            st.push_back(S(1'b0, 1'b1, 1'b0, 6'h00, fns[k])); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, fns[k])); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, fns[k])); ex.push_back(E(ST_EXEC, 1'b0, 1'b0, O_EXEC | {14'd0, ops[k]}));
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, fns[k])); ex.push_back(E(ST_ALUWB, 1'b0, 1'b0, O_ALUWB));
        end
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL rtype step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_MADR, 1'b0, 1'b0, O_MADR));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_MRD, 1'b0, 1'b0, O_MRD));
        end
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_MRD, 1'b0, 1'b0, O_MRD));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_MWB, 1'b0, 1'b0, O_MWB));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h23, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL lw_wait step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_sw();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MADR, 1'b0, 1'b0, O_MADR));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MWR, 1'b0, 1'b0, O_MWR));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL sw step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        for (int k = 0; k < 2; k++) begin
            st.push_back(S(1'b0, 1'b1, k == 0, 6'h04, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
            st.push_back(S(1'b0, 1'b0, k == 0, 6'h04, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
            st.push_back(S(1'b0, 1'b0, k == 0, 6'h04, 6'd0)); ex.push_back(E(ST_BR, 1'b0, 1'b0, O_BR));
        end
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h04, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL branch step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_jumps_imm();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_JMP, 1'b0, 1'b0, O_JMP));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h00, 6'd8)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, 6'd8)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, 6'd8)); ex.push_back(E(ST_JR, 1'b0, 1'b0, O_JR));
        for (int k = 0; k < 2; k++) begin
            st.push_back(S(1'b0, 1'b1, 1'b0, (k == 0) ? 6'h08 : 6'h09, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
            st.push_back(S(1'b0, 1'b0, 1'b0, (k == 0) ? 6'h08 : 6'h09, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
            st.push_back(S(1'b0, 1'b0, 1'b0, (k == 0) ? 6'h08 : 6'h09, 6'd0)); ex.push_back(E(ST_IMMEX, 1'b0, 1'b0, O_IMMEX));
            st.push_back(S(1'b0, 1'b0, 1'b0, (k == 0) ? 6'h08 : 6'h09, 6'd0)); ex.push_back(E(ST_IMMWB, 1'b0, 1'b0, O_IMMWB));
        end
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL jumps_imm step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_illegal();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h3F, 6'd0));  ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h3F, 6'd0));  ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h00, 6'd38)); ex.push_back(E(ST_FETCH, 1'b1, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h00, 6'd38)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h02, 6'd0));  ex.push_back(E(ST_FETCH, 1'b1, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0));  ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0));  ex.push_back(E(ST_JMP, 1'b0, 1'b0, O_JMP));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0));  ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL illegal step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_sw_timeout();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MADR, 1'b0, 1'b0, O_MADR));
        for (int k = 0; k < 15; k++) begin
            st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MWR, 1'b0, 1'b0, O_MWR));
        end
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MWR, 1'b0, 1'b0, O_MWR_OFF));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b1, O_FWAIT));
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_JMP, 1'b0, 1'b0, O_JMP));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h02, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL sw_timeout step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid_instr();
        logic [14:0] st [$];
        logic [23:0] ex [$];
        logic [14:0] s;
        st.push_back(S(1'b0, 1'b1, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FGO));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_DEC, 1'b0, 1'b0, O_DEC));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MADR, 1'b0, 1'b0, O_MADR));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MWR, 1'b0, 1'b0, O_MWR));
        st.push_back(S(1'b1, 1'b1, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_MWR, 1'b0, 1'b0, O_MWR_OFF));
        st.push_back(S(1'b0, 1'b0, 1'b0, 6'h2B, 6'd0)); ex.push_back(E(ST_FETCH, 1'b0, 1'b0, O_FWAIT));
        for (int i = 0; i < ex.size(); i++) begin
            s = st[i];
            rst = s[14]; mem_ready = s[13]; zero = s[12]; opcode = s[11:6]; func = s[5:0];
            #1;
            n_checks++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL reset_mid_instr step %0d: got %h expected %h", i, obs, ex[i]);
            end
            if (i != ex.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_timeout();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jumps_imm();
        test_illegal();
        test_sw_timeout();
        test_reset_mid_instr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
